// File: rtl/register_file_16_bit.sv
// Register file: one synchronous write port and two combinational read ports.
// Defining REGFILE_BYPASS_EN forwards same-cycle write data to a matching read port.
module register_file_16_bit #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic wr_zero;
    logic rd_zero_a;
    logic rd_zero_b;
    logic wr_ok;

    // Register 0 is only special when it is hard-wired.
    assign wr_zero   = (ZERO_REG != 0) && (waddr == '0);
    assign rd_zero_a = (ZERO_REG != 0) && (raddr_a == '0);
    assign rd_zero_b = (ZERO_REG != 0) && (raddr_b == '0);
    assign wr_ok     = we && !wr_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // Forwarding is held off during reset so the write that reset discards never leaks out.
    assign fwd_a = !rst && wr_ok && (waddr == raddr_a);
    assign fwd_b = !rst && wr_ok && (waddr == raddr_b);

    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
        if (fwd_a) rdata_a = wdata;
        if (fwd_b) rdata_b = wdata;
        if (rd_zero_a) rdata_a = '0;
        if (rd_zero_b) rdata_b = '0;
    end
`else
    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
        if (rd_zero_a) rdata_a = '0;
        if (rd_zero_b) rdata_b = '0;
    end
`endif

endmodule

// File: tb/tb_register_file_16_bit.sv
// Directed bench for register_file_16_bit: one instance with a hard-wired r0
// and one with an ordinary r0, sharing all inputs.
module tb_register_file_16_bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] rdata_a1, rdata_b1;
    logic [15:0] rdata_a0, rdata_b0;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    register_file_16_bit #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(1)) dut_z1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a1), .rdata_b(rdata_b1)
    );

    register_file_16_bit #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(0)) dut_z0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a0), .rdata_b(rdata_b0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs settle and are checked before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] walk(input int i);
        logic [15:0] one;
        one = 16'h0001;
        return (i == 0) ? 16'h0000 : (one << i);
    endfunction

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        tick();
        rst = 1'b0;

        // Everything reads zero after reset.
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i);
            raddr_b = 3'(7 - i);
            #1;
            check($sformatf("reset_a1_r%0d", i), rdata_a1, 16'h0000);
            check($sformatf("reset_b1_r%0d", 7 - i), rdata_b1, 16'h0000);
            check($sformatf("reset_a0_r%0d", i), rdata_a0, 16'h0000);
            check($sformatf("reset_b0_r%0d", 7 - i), rdata_b0, 16'h0000);
        end

        // Basic write then read on both ports.
        we = 1'b1; waddr = 3'd3; wdata = 16'hA5A5;
        tick();
        we = 1'b0; raddr_a = 3'd3; raddr_b = 3'd3;
        #1;
        check("r3_a1", rdata_a1, 16'hA5A5);
        check("r3_b1", rdata_b1, 16'hA5A5);
        check("r3_a0", rdata_a0, 16'hA5A5);

        // we=0 holds storage regardless of waddr/wdata.
        waddr = 3'd3; wdata = 16'h0F0F;
        tick();
        check("hold_r3_a1", rdata_a1, 16'hA5A5);
        check("hold_r3_b0", rdata_b0, 16'hA5A5);

        // Write 0xFFFF to r0 while reading r0 in the same cycle.
        we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; raddr_a = 3'd0; raddr_b = 3'd0;
        #1;
        check("r0_same_a1", rdata_a1, 16'h0000);
        check("r0_same_a0", rdata_a0, BYPASS ? 16'hFFFF : 16'h0000);
        tick();
        we = 1'b0;
        #1;
        check("r0_zero_a1", rdata_a1, 16'h0000);
        check("r0_zero_b1", rdata_b1, 16'h0000);
        check("r0_plain_a0", rdata_a0, 16'hFFFF);
        check("r0_plain_b0", rdata_b0, 16'hFFFF);

        // Same-cycle read of the register being written.
        we = 1'b1; waddr = 3'd5; wdata = 16'h1234;
        tick();
        waddr = 3'd5; wdata = 16'h5678; raddr_a = 3'd5; raddr_b = 3'd3;
        #1;
        check("r5_same_a1", rdata_a1, BYPASS ? 16'h5678 : 16'h1234);
        check("r5_same_a0", rdata_a0, BYPASS ? 16'h5678 : 16'h1234);
        check("r5_same_b1_r3", rdata_b1, 16'hA5A5);
        tick();
        we = 1'b0;
        #1;
        check("r5_next_a1", rdata_a1, 16'h5678);
        check("r5_next_a0", rdata_a0, 16'h5678);

        // Reset wins over a simultaneous write; no forwarding while in reset.
        rst = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 16'hBEEF; raddr_a = 3'd2; raddr_b = 3'd5;
        #1;
        check("rst_same_a1_r2", rdata_a1, 16'h0000);
        check("rst_same_a0_r2", rdata_a0, 16'h0000);
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        check("rst_r2_a1", rdata_a1, 16'h0000);
        check("rst_r2_a0", rdata_a0, 16'h0000);
        check("rst_r5_b1", rdata_b1, 16'h0000);
        check("rst_r5_b0", rdata_b0, 16'h0000);

        // Walking one across r1..r7, then every read-address pair.
        for (int i = 1; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = walk(i);
            tick();
        end
        we = 1'b0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                raddr_a = 3'(a);
                raddr_b = 3'(b);
                #1;
                check($sformatf("walk_a1_%0d_%0d", a, b), rdata_a1, walk(a));
                check($sformatf("walk_b1_%0d_%0d", a, b), rdata_b1, walk(b));
                check($sformatf("walk_a0_%0d_%0d", a, b), rdata_a0, walk(a));
                check($sformatf("walk_b0_%0d_%0d", a, b), rdata_b0, walk(b));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
